// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizer, 4-state qualification FSM and stability
// counter, producing a clean level plus one-cycle rise/fall pulses.
module button_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in};
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (sync) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                // Any low sample restarts qualification from scratch.
                if (!sync) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            IDLE_HIGH: begin
                if (!sync) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues expected output
// snapshots per cycle, a monitor pops and compares them after each edge.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level, btn_rise, btn_fall, busy;

    button_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_WIDTH    (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        logic  rise;
        logic  fall;
        logic  level;
        logic  bsy;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   rise_seen = 0;
    int   fall_seen = 0;
    int   both_seen = 0;
    int   rise_exp = 0;
    int   fall_exp = 0;

    function automatic void expect_at(int c, logic r, logic f, logic l, logic b, string n);
        exp_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.level = l; e.bsy = b; e.name = n;
        sb.push_back(e);
    endfunction

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (btn_rise) rise_seen++;
            if (btn_fall) fall_seen++;
            if (btn_rise && btn_fall) both_seen++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if (e.cyc < cyc) begin
                    $display("FAIL %s: snapshot for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
                end else if (btn_rise !== e.rise || btn_fall !== e.fall ||
                             btn_level !== e.level || busy !== e.bsy) begin
                    $display("FAIL %s @%0d: got rise=%b fall=%b level=%b busy=%b, need rise=%b fall=%b level=%b busy=%b",
                             e.name, cyc, btn_rise, btn_fall, btn_level, busy,
                             e.rise, e.fall, e.level, e.bsy);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic final_check(string n, int got, int need);
        n_checks++;
        if (got !== need) $display("FAIL %s: got %0d, need %0d", n, got, need);
        else n_pass++;
    endtask

    initial begin
        int b;
        int r;
        logic [5:0] bounce;

        reset  = 1'b1;
        btn_in = 1'b0;
        expect_at(2, 0, 0, 0, 0, "reset_state");
        step(3);
        reset = 1'b0;

        // Idle low for 20 cycles
        b = cyc;
        for (int i = 1; i <= 20; i++) expect_at(b + i, 0, 0, 0, 0, "idle_low");
        step(20);

        // Clean press
        b = cyc;
        btn_in = 1'b1;
        expect_at(b + 2, 0, 0, 0, 0, "press_sync");
        expect_at(b + 3, 0, 0, 0, 1, "press_busy");
        expect_at(b + 6, 0, 0, 0, 1, "press_wait");
        expect_at(b + 7, 1, 0, 1, 0, "press_rise");
        expect_at(b + 8, 0, 0, 1, 0, "press_rise_end");
        rise_exp++;
        step(10);

        // Clean release
        b = cyc;
        btn_in = 1'b0;
        expect_at(b + 3, 0, 0, 1, 1, "release_busy");
        expect_at(b + 6, 0, 0, 1, 1, "release_wait");
        expect_at(b + 7, 0, 1, 0, 0, "release_fall");
        expect_at(b + 8, 0, 0, 0, 0, "release_fall_end");
        fall_exp++;
        step(10);

        // 4-cycle glitch: rejected
        b = cyc;
        btn_in = 1'b1;
        expect_at(b + 3, 0, 0, 0, 1, "glitch4_busy");
        expect_at(b + 6, 0, 0, 0, 1, "glitch4_wait");
        expect_at(b + 7, 0, 0, 0, 0, "glitch4_reject");
        expect_at(b + 8, 0, 0, 0, 0, "glitch4_quiet");
        step(4);
        btn_in = 1'b0;
        step(8);

        // 5-cycle pulse: accepted, then released
        b = cyc;
        btn_in = 1'b1;
        expect_at(b + 7, 1, 0, 1, 0, "pulse5_rise");
        expect_at(b + 8, 0, 0, 1, 1, "pulse5_release_busy");
        expect_at(b + 12, 0, 1, 0, 0, "pulse5_fall");
        rise_exp++;
        fall_exp++;
        step(5);
        btn_in = 1'b0;
        step(15);

        // Bouncy press: 1,0,1,1,0,1 then steady 1
        b = cyc;
        bounce = 6'b101101;
        expect_at(b + 3, 0, 0, 0, 1, "bounce_busy");
        expect_at(b + 4, 0, 0, 0, 0, "bounce_reject1");
        expect_at(b + 7, 0, 0, 0, 0, "bounce_reject2");
        expect_at(b + 11, 0, 0, 0, 1, "bounce_wait");
        expect_at(b + 12, 1, 0, 1, 0, "bounce_rise");
        expect_at(b + 13, 0, 0, 1, 0, "bounce_rise_end");
        rise_exp++;
        for (int i = 5; i >= 0; i--) begin
            btn_in = bounce[i];
            step(1);
        end
        btn_in = 1'b1;
        step(10);
        b = cyc;
        btn_in = 1'b0;
        expect_at(b + 7, 0, 1, 0, 0, "bounce_release_fall");
        fall_exp++;
        step(12);

        // Reset 2 cycles into WAIT_HIGH, button still held afterwards
        b = cyc;
        btn_in = 1'b1;
        expect_at(b + 4, 0, 0, 0, 1, "rst_wait_busy");
        step(4);
        reset = 1'b1;
        expect_at(b + 5, 0, 0, 0, 0, "rst_mid_wait_a");
        expect_at(b + 7, 0, 0, 0, 0, "rst_mid_wait_b");
        step(3);
        reset = 1'b0;
        r = cyc;
        expect_at(r + 2, 0, 0, 0, 0, "rst_resync");
        expect_at(r + 3, 0, 0, 0, 1, "rst_requal_busy");
        expect_at(r + 6, 0, 0, 0, 1, "rst_requal_wait");
        expect_at(r + 7, 1, 0, 1, 0, "rst_requal_rise");
        expect_at(r + 8, 0, 0, 1, 0, "rst_requal_rise_end");
        rise_exp++;
        step(10);

        // Reset while high: level drops, no fall pulse; re-qualified
        b = cyc;
        reset = 1'b1;
        expect_at(b + 1, 0, 0, 0, 0, "rst_high_nofall");
        expect_at(b + 2, 0, 0, 0, 0, "rst_high_hold");
        step(2);
        reset = 1'b0;
        r = cyc;
        expect_at(r + 7, 1, 0, 1, 0, "rst_high_rise");
        rise_exp++;
        step(10);

        // Held for 1000 cycles: level stays high, no pulses
        b = cyc;
        for (int i = 50; i <= 1000; i += 50) expect_at(b + i, 0, 0, 1, 0, "held_high");
        step(1000);
        b = cyc;
        btn_in = 1'b0;
        expect_at(b + 7, 0, 1, 0, 0, "held_release_fall");
        expect_at(b + 8, 0, 0, 0, 0, "held_release_end");
        fall_exp++;
        step(12);

        final_check("rise_pulse_count", rise_seen, rise_exp);
        final_check("fall_pulse_count", fall_seen, fall_exp);
        final_check("rise_fall_overlap", both_seen, 0);
        final_check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
